// File: rtl/mult_sequencer.sv
// Iterative shift-and-add multiplier for the EX stage. It borrows the shared ALU
// for its adds and shifts, and it stalls the pipeline while a multiply runs.
module mult_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_reg1,
  output logic [WIDTH-1:0] alu_reg2,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_shift,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // state   | meaning
  // S_IDLE  | waiting for start; ALU belongs to the pipeline
  // S_ADD   | P <= P + M through the ALU
  // S_SHIFT | M <= M << 1 through the ALU, Q shifted locally, cnt advanced
  // S_DONE  | done pulse; result captured on the edge leaving this state

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] p, m, q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_shr;
  logic [CW-1:0]    cnt_inc;
  logic             accept;

  assign q_shr   = q >> 1;
  assign cnt_inc = cnt + 1'b1;
  assign accept  = (state == S_IDLE) && start && !flush;

  // Next step after loading or after a shift, given the multiplier still
  // remaining and the number of shift steps already done.
  function automatic state_t decide(input logic [WIDTH-1:0] qv,
                                    input logic [CW-1:0]    c);
    if ((EARLY_EXIT && (qv == '0)) || (c == CW'(WIDTH)))
      return S_DONE;
    else if (qv[0])
      return S_ADD;
    else
      return S_SHIFT;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = decide(b, '0);
      S_ADD:   state_nxt = flush ? S_IDLE : S_SHIFT;
      S_SHIFT: state_nxt = flush ? S_IDLE : decide(q_shr, cnt_inc);
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alu_sel   = 1'b0;
    alu_reg1  = '0;
    alu_reg2  = '0;
    alu_op    = 3'b000;
    alu_shift = 4'd0;
    case (state)
      S_ADD: begin
        alu_sel  = 1'b1;
        alu_reg1 = p;
        alu_reg2 = m;
        alu_op   = OP_ADD;
      end
      S_SHIFT: begin
        alu_sel   = 1'b1;
        alu_reg1  = m;
        alu_op    = OP_SLL;
        alu_shift = 4'd1;
      end
      default: ;
    endcase
  end

  // The request-cycle term is combinational, so the pipeline freezes on the
  // same cycle that start is seen.
  assign stall = accept || (state == S_ADD) || (state == S_SHIFT);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p      <= '0;
      m      <= '0;
      q      <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            p   <= '0;
            m   <= a;
            q   <= b;
            cnt <= '0;
          end
        end
        S_ADD: begin
          if (!flush) p <= alu_result;
        end
        S_SHIFT: begin
          if (!flush) begin
            m   <= alu_result;
            q   <= q_shr;
            cnt <= cnt_inc;
          end
        end
        S_DONE:  result <= p;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: two instances (early exit on and off) share one set
// of inputs and are checked against a plain-arithmetic multiply/timing model.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        alu_sel_e, stall_e, busy_e, done_e;
  logic [31:0] alu_reg1_e, alu_reg2_e, alu_result_e, result_e;
  logic [2:0]  alu_op_e;
  logic [3:0]  alu_shift_e;

  logic        alu_sel_f, stall_f, busy_f, done_f;
  logic [31:0] alu_reg1_f, alu_reg2_f, alu_result_f, result_f;
  logic [2:0]  alu_op_f;
  logic [3:0]  alu_shift_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [3:0] sh);
    case (op)
      3'b010:  return r1 + r2;
      3'b011:  return r1 << sh;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result_e = alu_f(alu_op_e, alu_reg1_e, alu_reg2_e, alu_shift_e);
  assign alu_result_f = alu_f(alu_op_f, alu_reg1_f, alu_reg2_f, alu_shift_f);

  mult_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .a(a), .b(b),
    .alu_result(alu_result_e), .alu_sel(alu_sel_e), .alu_reg1(alu_reg1_e),
    .alu_reg2(alu_reg2_e), .alu_op(alu_op_e), .alu_shift(alu_shift_e),
    .stall(stall_e), .busy(busy_e), .done(done_e), .result(result_e));

  mult_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .a(a), .b(b),
    .alu_result(alu_result_f), .alu_sel(alu_sel_f), .alu_reg1(alu_reg1_f),
    .alu_reg2(alu_reg2_f), .alu_op(alu_op_f), .alu_shift(alu_shift_f),
    .stall(stall_f), .busy(busy_f), .done(done_f), .result(result_f));

  wire [106:0] outs_e = {alu_sel_e, alu_reg1_e, alu_reg2_e, alu_op_e, alu_shift_e,
                         stall_e, busy_e, done_e, result_e};
  wire [106:0] outs_f = {alu_sel_f, alu_reg1_f, alu_reg2_f, alu_op_f, alu_shift_f,
                         stall_f, busy_f, done_f, result_f};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One multiply on both instances; optionally re-pulse start mid-operation.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit repulse);
    int pop, msb, exp_e, exp_f;
    int d_e, d_f, n_done_e, n_done_f, n_sel, n_stall;
    logic [31:0] prod;
    pop = 0;
    msb = -1;
    for (int i = 0; i < 32; i++)
      if (bv[i]) begin
        pop++;
        msb = i;
      end
    exp_e = (bv == 0) ? 1 : pop + (msb + 1) + 1;
    exp_f = pop + 32 + 1;
    prod  = av * bv;
    d_e = 0; d_f = 0; n_done_e = 0; n_done_f = 0; n_sel = 0; n_stall = 0;

    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    #1 chk("stall_in_request_cycle", stall_e, 1'b1);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      if (done_e) begin n_done_e++; if (d_e == 0) d_e = k; end
      if (done_f) begin n_done_f++; if (d_f == 0) d_f = k; end
      n_sel   += int'(alu_sel_e);
      n_stall += int'(stall_e);
      if (d_e != 0 && k == d_e + 1) chk("result_early", result_e, prod);
      if (d_f != 0 && k == d_f + 1) begin
        chk("result_full", result_f, prod);
        break;
      end
      if (repulse) start = (k == 2);
      @(negedge clk);
    end
    start = 1'b0;
    if (d_f == 0) chk("timeout_waiting_done", 0, 1);
    chk("cycles_early", d_e, exp_e);
    chk("cycles_full", d_f, exp_f);
    chk("alu_sel_cycles", n_sel, exp_e - 1);
    chk("stall_cycles", n_stall, exp_e - 1);
    chk("done_pulses_early", n_done_e, 1);
    chk("done_pulses_full", n_done_f, 1);
  endtask

  initial begin
    logic [31:0] prev;
    int seen_done;

    #3;
    chk("reset_outs_early", outs_e, '0);
    chk("reset_outs_full", outs_f, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd3, 32'd5, 1'b0);
    run_op(32'hFFFFFFF9, 32'd6, 1'b0);
    run_op(32'h12345678, 32'd0, 1'b0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(32'd3, 32'd5, 1'b1);

    // Flush during the 3rd cycle: back to IDLE, no done, result kept.
    prev = result_e;
    @(negedge clk);
    a = 32'd9;
    b = 32'hFF;
    start = 1'b1;
    seen_done = 0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      seen_done += int'(done_e) + int'(done_f);
      if (k == 3) flush = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    flush = 1'b0;
    seen_done += int'(done_e) + int'(done_f);
    chk("flush_busy_early", busy_e, 1'b0);
    chk("flush_busy_full", busy_f, 1'b0);
    chk("flush_no_done", seen_done, 0);
    chk("flush_result_kept_early", result_e, prev);
    chk("flush_result_kept_full", result_f, prev);

    // flush beats start in IDLE.
    start = 1'b1;
    flush = 1'b1;
    #1 chk("flush_start_no_stall", stall_e, 1'b0);
    @(negedge clk);
    chk("flush_start_not_accepted", {busy_e, busy_f}, 2'b00);
    start = 1'b0;
    flush = 1'b0;

    for (int n = 0; n < 20; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (n % 4 == 3) rb = rb & $urandom;
      run_op(ra, rb, 1'b0);
    end

    // Asynchronous reset while in ADD.
    @(negedge clk);
    a = 32'd7;
    b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("in_add_before_reset", alu_op_e, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs_early", outs_e, '0);
    chk("async_reset_outs_full", outs_f, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd2, 32'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Iterative 32-bit multiply controller for the EX stage of the pipelined MIPS processor. It borrows the shared EX-stage ALU through the ALU operand mux and computes a shift-and-add product from ALU add (`010`) and shift-left (`011`) operations. While it runs, it stalls the pipeline. It returns the low 32 bits of the product with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 32: operand/result width; must match the ALU width.
- `EARLY_EXIT`, 1: 1 = terminate when the remaining multiplier is zero; 0 = always run `WIDTH` shift steps.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  multiply request; sampled only in IDLE.
- `flush`  in  1  synchronous abort from branch/flush logic.
- `a`  in  WIDTH  multiplicand; latched on accepted `start`.
- `b`  in  WIDTH  multiplier; latched on accepted `start`.
- `alu_result`  in  WIDTH  shared ALU output.
- `alu_sel`  out  1  ALU operand mux control: 1 = sequencer owns the ALU, 0 = pipeline owns it.
- `alu_reg1`  out  WIDTH  ALU operand 1.
- `alu_reg2`  out  WIDTH  ALU operand 2.
- `alu_op`  out  3  ALU opcode.
- `alu_shift`  out  4  ALU shift amount.
- `stall`  out  1  freeze the upstream pipeline stages.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  product low word; registered; held until the next accepted `start`.

## Operation
- Registers: `P` (partial product), `M` (shifted multiplicand), `Q` (remaining multiplier), `cnt` (shift steps done, 0..WIDTH), and `state`.
- States: IDLE, ADD, SHIFT, DONE.
- `decide(q)`:
  - DONE if (`EARLY_EXIT` and q==0) or `cnt`==WIDTH.
  - Else ADD if q[0]==1.
  - Else SHIFT.
- IDLE: when `start` is high, latch M=`a`, Q=`b`, P=0, cnt=0, and go to `decide(b)`.
- ADD: drive reg1=P, reg2=M, op=`010`, shift=0. Capture P<=`alu_result`, then go to SHIFT.
- SHIFT: drive reg1=M, reg2=0, op=`011`, shift=1. Capture M<=`alu_result`, Q<=Q>>1 (local logical shift, no ALU use), cnt<=cnt+1, then go to `decide(Q>>1)`.
- DONE: `result`<=P, `done`=1 for this cycle, then go to IDLE.
- `alu_sel`=1 only in ADD and SHIFT. In all other states the ALU outputs are 0 and `alu_result` is ignored.
- Arithmetic is modulo 2^WIDTH. The two's-complement low word is correct for signed and unsigned operands. Bits shifted out of M are discarded.
- `stall` = (IDLE and `start` and not `flush`) or ADD or SHIFT. It is low in DONE so the pipeline advances on the cycle `result` becomes valid.
- `start` is ignored in ADD, SHIFT and DONE. It is not queued; the requester holds it until `stall` drops.
- `flush` in any non-IDLE state moves to IDLE on the next edge: no `done` pulse, `result` unchanged. `flush` with `start` in IDLE: `flush` wins and the request is not accepted.
- Reset (asynchronous, any time, including mid-operation): state=IDLE, and P, M, Q, cnt, `result` = 0. All outputs are 0.

## Timing
- Reset values: `alu_sel`, `alu_reg1`, `alu_reg2`, `alu_op`, `alu_shift`, `stall`, `busy`, `done` and `result` are all 0.
- `start` accepted at edge E0. With `EARLY_EXIT`=1, the number of cycles from E0 to and including the DONE cycle is popcount(b) + (msb_index(b)+1) + 1. For b=0 it is 1.
- Worst case (b=0xFFFFFFFF): 32 ADD + 32 SHIFT + 1 DONE = 65 cycles.
- With `EARLY_EXIT`=0: popcount(b) + WIDTH + 1 cycles.
- `result` updates on the edge that leaves DONE and is valid from the cycle after the `done` pulse. The pipeline captures `result` on the first edge after DONE; `stall` is already low in the DONE cycle.
- `stall` is combinational in the request cycle (same cycle as `start`), so the pipeline freezes without a bubble.

## Test plan
- a=3, b=5 -> sequence ADD, SHIFT, SHIFT, ADD, SHIFT, DONE; `done` on the 6th cycle after acceptance; `result`=15; `alu_sel` high for 5 cycles.
- a=0xFFFFFFF9 (-7), b=6 -> 6 cycles; `result`=0xFFFFFFD6 (-42).
- a=0x12345678, b=0 -> DONE one cycle after acceptance; `result`=0, with no ALU borrow. Repeat with `EARLY_EXIT`=0 -> 33 cycles, `result`=0.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> 65 cycles; `result`=0x00000001; `stall` high for exactly 64 cycles after the request cycle.
- `start` pulsed again during SHIFT -> ignored; one `done` only. `flush` during the 3rd cycle -> IDLE next edge, no `done`, `result` unchanged from the previous value.
- `rst_n` low asynchronously mid-ADD -> all outputs 0 immediately. After release, a=2, b=2 -> `result`=4 in 4 cycles.
